pln_eval: RTL and testbench
===========================

Name: pln_eval

Overview:
- Reverse-Polish evaluation stage sitting directly downstream of pln_fsm.
- Consumes the postfix token stream pln_fsm produces from an infix expression (e.g. "1+5*5" arrives as 1 5 5 * + END) and evaluates it on an internal operand stack.
- Returns one signed result per expression, with error and overflow status, over a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width, two's complement.
- DEPTH, 16, operand stack entries (power of 2, >=2).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- TOK_VALID  in  1  token present.
- TOK_READY  out  1  stage can accept token this cycle.
- TOK_KIND  in  2  00 NUM, 01 OP, 10 END, 11 reserved.
- TOK_DATA  in  DATA_W  NUM: signed operand; OP: ASCII code in [7:0].
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer takes result.
- RES_DATA  out  DATA_W  expression value.
- RES_ERR  out  3  0 OK, 1 stack underflow, 2 stack overflow, 3 bad opcode/kind, 4 END with depth != 1.
- RES_OVF  out  1  arithmetic overflow occurred in this expression (sticky).

Behaviour:
- Reset (RST low, asynchronous): state ACCEPT, sp=0, TOK_READY=0 until first edge after release then 1, RES_VALID=0, RES_DATA=0, RES_ERR=0, RES_OVF=0. Stack contents undefined; not cleared.
- Token transfer occurs on an edge with TOK_VALID & TOK_READY. TOK_READY is 1 only in ACCEPT and DRAIN.
- States:
  - ACCEPT:
    - NUM: push (sp<DEPTH) and stay; at sp==DEPTH set err=2, go to DRAIN.
    - OP: latch opcode; if sp<2, err=1, go to DRAIN; else go to APPLY.
    - END: if sp==1, RES_DATA<=stack[0], go to DONE; else err=4, go to DONE.
    - Kind 11: err=3, go to DRAIN.
  - APPLY (1 cycle, TOK_READY=0): a=stack[sp-2], b=stack[sp-1]; result replaces a, sp<=sp-1, return to ACCEPT.
    - '+' (0x2B): a+b. '-' (0x2D): a-b. '*' (0x2A): low DATA_W bits of the signed product.
    - Any other code: err=3, go to DRAIN, stack unchanged.
    - Overflow: signed overflow on +/-, or product not representable in DATA_W, sets the ovf flag. It does not abort evaluation.
  - DRAIN: accept and discard tokens until END, then go to DONE. The first error is kept; later errors are ignored.
  - DONE: RES_VALID=1 with RES_DATA/RES_ERR/RES_OVF stable. On RES_READY: RES_VALID<=0, sp<=0, err/ovf cleared, go to ACCEPT. TOK_READY=0 while in DONE.
- RES_DATA=0 whenever err!=0.
- Latency:
  - NUM: 1 token/cycle.
  - OP: 2 cycles (accept + APPLY).
  - END to RES_VALID: 1 cycle.
  - RES_READY may already be high when RES_VALID rises; the result is taken on that edge, and ACCEPT resumes the next cycle.
- Back-to-back expressions: the first token of the next expression is not accepted until the previous result has been taken.
- RST asserted mid-expression discards all state immediately; no partial result is emitted.

Decomposition:
- Shared package pln_pkg:
  - token kind enum (TK_NUM, TK_OP, TK_END), also used by pln_fsm's output side.
  - opcode constants OP_ADD/OP_SUB/OP_MUL (ASCII).
  - error code enum.
  - state enum.
- One sub-module, pln_stack:
  - DEPTH x DATA_W register stack with sp.
  - push, pop2-push1 (replace) and clear ops.
  - exposes top and next-to-top combinationally.
  - full/empty/depth outputs.
- Arithmetic and the FSM stay in pln_eval.

Test Plan:
- Tokens 1,5,5,*,+,END back-to-back, RES_READY=1 -> RES_VALID one cycle after END; RES_DATA=26, RES_ERR=0, RES_OVF=0.
- 7,10,-,END then 3,4,*,END, RES_READY held low 5 cycles -> first result -3 held stable with TOK_READY=0; after take, second result 12.
- 0x7FFFFFFF,1,+,END -> RES_DATA=0x80000000, RES_OVF=1, RES_ERR=0. 0x10000,0x10000,*,END -> RES_DATA=0, RES_OVF=1.
- Error cases:
  - 5,+,3,END -> RES_ERR=1, RES_DATA=0; 3 and END are drained.
  - 17 NUMs then END (DEPTH=16) -> RES_ERR=2.
  - 1,2,END -> RES_ERR=4.
  - OP 0x2F -> RES_ERR=3.
- RST pulled low for 1 cycle after 1,5 accepted, then 2,3,+,END -> result 5 with RES_ERR=0, no stale result.
- Random TOK_VALID gaps and random RES_READY stalls over 1000 random valid expressions -> results match a reference model; no token lost or duplicated.

Source files
------------

// File: rtl/pln_pkg.sv
// Shared types for the postfix pipeline: token kinds, opcodes, error codes and
// evaluator states.
package pln_pkg;

    typedef enum logic [1:0] {
        TK_NUM = 2'b00,
        TK_OP  = 2'b01,
        TK_END = 2'b10,
        TK_RSV = 2'b11
    } tok_kind_e;

    localparam logic [7:0] OP_ADD = 8'h2B;
    localparam logic [7:0] OP_SUB = 8'h2D;
    localparam logic [7:0] OP_MUL = 8'h2A;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_UNDER = 3'd1,
        ERR_OVER  = 3'd2,
        ERR_BAD   = 3'd3,
        ERR_DEPTH = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_APPLY,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pln_eval_if.sv
// Token-in / result-out handshake bundle between pln_fsm, pln_eval and the
// result consumer.
interface pln_eval_if #(
    parameter int unsigned DATA_W = 32
);
    logic              TOK_VALID;
    logic              TOK_READY;
    logic [1:0]        TOK_KIND;
    logic [DATA_W-1:0] TOK_DATA;
    logic              RES_VALID;
    logic              RES_READY;
    logic [DATA_W-1:0] RES_DATA;
    logic [2:0]        RES_ERR;
    logic              RES_OVF;

    // Environment side: token producer and result consumer.
    modport master (
        output TOK_VALID, TOK_KIND, TOK_DATA, RES_READY,
        input  TOK_READY, RES_VALID, RES_DATA, RES_ERR, RES_OVF
    );

    // Evaluator side.
    modport slave (
        input  TOK_VALID, TOK_KIND, TOK_DATA, RES_READY,
        output TOK_READY, RES_VALID, RES_DATA, RES_ERR, RES_OVF
    );
endinterface

// File: rtl/pln_stack.sv
// Register operand stack: push, pop-two-push-one (replace) and clear, with the
// top two entries visible combinationally.
module pln_stack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     repl,
    input  logic                     clr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        top,
    output logic [DATA_W-1:0]        nxt,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned SPW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [SPW-1:0]    sp;
    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     nxt_idx;

    // Index arithmetic wraps modulo DEPTH, so sp==DEPTH still addresses entry DEPTH-1.
    assign top_idx = sp[AW-1:0] - AW'(1);
    assign nxt_idx = sp[AW-1:0] - AW'(2);

    assign top   = mem[top_idx];
    assign nxt   = mem[nxt_idx];
    assign full  = (sp == SPW'(DEPTH));
    assign empty = (sp == '0);
    assign depth = sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (clr) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (repl && (sp >= SPW'(2))) begin
            sp <= sp - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            if (push && !full) begin
                mem[sp[AW-1:0]] <= wdata;
            end else if (repl && (sp >= SPW'(2))) begin
                mem[nxt_idx] <= wdata;
            end
        end
    end

endmodule

// File: rtl/pln_eval.sv
// Reverse-Polish evaluator: consumes postfix tokens, runs +,-,* on an operand
// stack and returns one result per expression with error/overflow status.
import pln_pkg::*;

module pln_eval #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic      CLK,
    input  logic      RST,
    pln_eval_if.slave bus
);
    localparam int unsigned SPW = $clog2(DEPTH) + 1;

    state_e              state, state_n;
    err_e                err, err_n;
    logic                ovf, ovf_n;
    logic [DATA_W-1:0]   res_data, res_n;
    logic [7:0]          op, op_n;
    logic                armed;

    logic                push, repl, clr;
    logic [DATA_W-1:0]   wdata, top, nxt;
    logic                full, empty;
    logic [SPW-1:0]      depth;

    logic                tok_fire;
    tok_kind_e           kind;
    logic [DATA_W-1:0]   sum, diff;
    logic [2*DATA_W-1:0] prod;
    logic                sum_ovf, diff_ovf, prod_ovf;

    pln_stack #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RST),
        .push  (push),
        .repl  (repl),
        .clr   (clr),
        .wdata (wdata),
        .top   (top),
        .nxt   (nxt),
        .full  (full),
        .empty (empty),
        .depth (depth)
    );

    assign kind          = tok_kind_e'(bus.TOK_KIND);
    assign bus.TOK_READY = armed && ((state == ST_ACCEPT) || (state == ST_DRAIN));
    assign tok_fire      = bus.TOK_VALID && bus.TOK_READY;
    assign bus.RES_VALID = (state == ST_DONE);
    assign bus.RES_DATA  = res_data;
    assign bus.RES_ERR   = err;
    assign bus.RES_OVF   = ovf;

    // a = nxt (older operand), b = top.
    assign sum  = nxt + top;
    assign diff = nxt - top;
    assign prod = {{DATA_W{nxt[DATA_W-1]}}, nxt} * {{DATA_W{top[DATA_W-1]}}, top};

    assign sum_ovf  = (nxt[DATA_W-1] == top[DATA_W-1]) && (sum[DATA_W-1] != nxt[DATA_W-1]);
    assign diff_ovf = (nxt[DATA_W-1] != top[DATA_W-1]) && (diff[DATA_W-1] != nxt[DATA_W-1]);
    // Product fits only if the upper half plus the result sign bit are all equal.
    assign prod_ovf = !((&prod[2*DATA_W-1:DATA_W-1]) || !(|prod[2*DATA_W-1:DATA_W-1]));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_ACCEPT;
            err      <= ERR_NONE;
            ovf      <= 1'b0;
            res_data <= '0;
            op       <= '0;
            armed    <= 1'b0;
        end else begin
            state    <= state_n;
            err      <= err_n;
            ovf      <= ovf_n;
            res_data <= res_n;
            op       <= op_n;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        err_n   = err;
        ovf_n   = ovf;
        res_n   = res_data;
        op_n    = op;
        push    = 1'b0;
        repl    = 1'b0;
        clr     = 1'b0;
        wdata   = bus.TOK_DATA;

        case (state)
            ST_ACCEPT: begin
                if (tok_fire) begin
                    case (kind)
                        TK_NUM: begin
                            if (full) begin
                                err_n   = ERR_OVER;
                                state_n = ST_DRAIN;
                            end else begin
                                push = 1'b1;
                            end
                        end
                        TK_OP: begin
                            op_n = bus.TOK_DATA[7:0];
                            if (empty || (depth == SPW'(1))) begin
                                err_n   = ERR_UNDER;
                                state_n = ST_DRAIN;
                            end else begin
                                state_n = ST_APPLY;
                            end
                        end
                        TK_END: begin
                            state_n = ST_DONE;
                            if (depth == SPW'(1)) begin
                                res_n = top;
                            end else begin
                                err_n = ERR_DEPTH;
                                res_n = '0;
                            end
                        end
                        default: begin
                            err_n   = ERR_BAD;
                            state_n = ST_DRAIN;
                        end
                    endcase
                end
            end
            ST_APPLY: begin
                state_n = ST_ACCEPT;
                case (op)
                    OP_ADD: begin
                        repl  = 1'b1;
                        wdata = sum;
                        ovf_n = ovf | sum_ovf;
                    end
                    OP_SUB: begin
                        repl  = 1'b1;
                        wdata = diff;
                        ovf_n = ovf | diff_ovf;
                    end
                    OP_MUL: begin
                        repl  = 1'b1;
                        wdata = prod[DATA_W-1:0];
                        ovf_n = ovf | prod_ovf;
                    end
                    default: begin
                        err_n   = ERR_BAD;
                        state_n = ST_DRAIN;
                    end
                endcase
            end
            ST_DRAIN: begin
                if (tok_fire && (kind == TK_END)) begin
                    state_n = ST_DONE;
                    res_n   = '0;
                end
            end
            ST_DONE: begin
                if (bus.RES_READY) begin
                    state_n = ST_ACCEPT;
                    clr     = 1'b1;
                    err_n   = ERR_NONE;
                    ovf_n   = 1'b0;
                end
            end
            default: state_n = ST_ACCEPT;
        endcase
    end

endmodule

// File: tb/tb_pln_eval.sv
// Directed and random bench for pln_eval: expected results are queued as each
// expression is driven and compared as the evaluator hands results over.
import pln_pkg::*;

module tb_pln_eval;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  err;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pln_eval_if #(.DATA_W(32)) bus ();

    pln_eval #(
        .DATA_W (32),
        .DEPTH  (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int          results  = 0;
    int          expected = 0;
    int          rr_mode  = 0;
    int unsigned gap_max  = 0;

    function automatic exp_t mk(input logic [31:0] d, input logic [2:0] e, input logic o);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.ovf  = o;
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Result consumer: 0 always ready, 1 never ready, 2 random stalls.
    initial begin
        bus.RES_READY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       bus.RES_READY = 1'b1;
                1:       bus.RES_READY = 1'b0;
                default: bus.RES_READY = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.RES_VALID && bus.RES_READY) begin
            results++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result: observed data=0x%08h err=%0d expected=no result",
                       bus.RES_DATA, bus.RES_ERR);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_data", bus.RES_DATA, e.data);
                chk("res_err", 32'(bus.RES_ERR), 32'(e.err));
                chk1("res_ovf", bus.RES_OVF, e.ovf);
            end
        end
    end

    task automatic send(input logic [1:0] k, input logic [31:0] d);
        int unsigned waited;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        bus.TOK_KIND  = k;
        bus.TOK_DATA  = d;
        bus.TOK_VALID = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.TOK_READY && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk1("tok_accept", bus.TOK_READY, 1'b1);
        @(posedge clk);
        #1;
        bus.TOK_VALID = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] d, input logic [2:0] e, input logic o);
        sb.push_back(mk(d, e, o));
        expected++;
    endtask

    task automatic num(input logic [31:0] d);
        send(2'b00, d);
    endtask

    task automatic opc(input logic [7:0] c);
        send(2'b01, {24'h0, c});
    endtask

    task automatic fin();
        send(2'b10, 32'h0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic int rand_val();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    task automatic rand_expr();
        int     st[$];
        int     n, pushed, a, b, r;
        longint w;
        logic   ovf;
        logic [7:0] c;
        ovf    = 1'b0;
        pushed = 0;
        n      = int'($urandom_range(1, 6));
        while (pushed < n || st.size() > 1) begin
            if (pushed < n && (st.size() < 2 || $urandom_range(0, 1) == 1)) begin
                a = rand_val();
                st.push_back(a);
                pushed++;
                num(a);
            end else begin
                b = st.pop_back();
                a = st.pop_back();
                case ($urandom_range(0, 2))
                    0: begin c = OP_ADD; w = longint'(a) + longint'(b); end
                    1: begin c = OP_SUB; w = longint'(a) - longint'(b); end
                    default: begin c = OP_MUL; w = longint'(a) * longint'(b); end
                endcase
                r = int'(w[31:0]);
                if (w != longint'(r)) ovf = 1'b1;
                st.push_back(r);
                opc(c);
            end
        end
        expect_res(st[0], 3'd0, ovf);
        fin();
    endtask

    initial begin
        rst           = 1'b0;
        bus.TOK_VALID = 1'b0;
        bus.TOK_KIND  = 2'b00;
        bus.TOK_DATA  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_res_valid", bus.RES_VALID, 1'b0);
        chk1("rst_tok_ready", bus.TOK_READY, 1'b0);
        chk("rst_res_data", bus.RES_DATA, 32'h0);
        chk("rst_res_err", 32'(bus.RES_ERR), 32'd0);
        chk1("rst_res_ovf", bus.RES_OVF, 1'b0);
        rst = 1'b1;
        #1;
        chk1("ready_before_edge", bus.TOK_READY, 1'b0);
        @(posedge clk);
        #1;
        chk1("ready_after_edge", bus.TOK_READY, 1'b1);

        // 1 5 5 * + END = 26, result one cycle after END
        num(1); num(5); num(5); opc(OP_MUL); opc(OP_ADD);
        expect_res(32'd26, 3'd0, 1'b0);
        fin();
        @(negedge clk);
        chk1("end_to_valid", bus.RES_VALID, 1'b1);
        wait_drain();

        // Held result while consumer stalls; next expression waits
        rr_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        num(7); num(10); opc(OP_SUB);
        expect_res(32'hFFFF_FFFD, 3'd0, 1'b0);
        fin();
        repeat (5) begin
            @(negedge clk);
            chk1("hold_valid", bus.RES_VALID, 1'b1);
            chk("hold_data", bus.RES_DATA, 32'hFFFF_FFFD);
            chk1("hold_tok_ready", bus.TOK_READY, 1'b0);
        end
        rr_mode = 0;
        num(3); num(4); opc(OP_MUL);
        expect_res(32'd12, 3'd0, 1'b0);
        fin();
        wait_drain();

        // Arithmetic overflow
        num(32'h7FFF_FFFF); num(1); opc(OP_ADD);
        expect_res(32'h8000_0000, 3'd0, 1'b1);
        fin();
        num(32'h0001_0000); num(32'h0001_0000); opc(OP_MUL);
        expect_res(32'h0, 3'd0, 1'b1);
        fin();
        num(32'h8000_0000); num(1); opc(OP_SUB);
        expect_res(32'h7FFF_FFFF, 3'd0, 1'b1);
        fin();

        // Error cases
        num(5); opc(OP_ADD); num(3);
        expect_res(32'h0, 3'd1, 1'b0);
        fin();
        for (int i = 0; i < 17; i++) num(32'(i));
        expect_res(32'h0, 3'd2, 1'b0);
        fin();
        num(1); num(2);
        expect_res(32'h0, 3'd4, 1'b0);
        fin();
        num(1); num(2); opc(8'h2F);
        expect_res(32'h0, 3'd3, 1'b0);
        fin();
        num(4); send(2'b11, 32'h0);
        expect_res(32'h0, 3'd3, 1'b0);
        fin();
        num(6); opc(OP_MUL); send(2'b11, 32'h0);
        expect_res(32'h0, 3'd1, 1'b0);
        fin();
        fin();
        expect_res(32'h0, 3'd4, 1'b0);
        wait_drain();

        // Reset mid-expression discards partial state
        num(1); num(5);
        rst = 1'b0;
        #1;
        chk1("midrst_tok_ready", bus.TOK_READY, 1'b0);
        chk1("midrst_res_valid", bus.RES_VALID, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        num(2); num(3); opc(OP_ADD);
        expect_res(32'd5, 3'd0, 1'b0);
        fin();
        wait_drain();

        // Random expressions with token gaps and consumer stalls
        gap_max = 2;
        rr_mode = 2;
        for (int i = 0; i < 1000; i++) rand_expr();
        wait_drain();
        chk("result_count", 32'(results), 32'(expected));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
